sign_ext: RTL and testbench

// - Immediate generator for the LEGv8 single-cycle/pipelined datapath; sits between instruction fetch and the ALU B-mux.
// - Decodes the opcode field of a 32-bit instruction, extracts the immediate field and sign-extends it to 64 bits.
// - Output is registered; unrecognised opcodes yield zero.

---
 rtl/legv8_pkg.sv | 28 ++
 rtl/imm_fmt_decode.sv | 29 ++
 rtl/sign_ext.sv | 59 +++++
 tb/tb_sign_ext.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module : legv8_pkg
// Brief  : LEGv8 opcode constants and immediate-format encoding shared by the
//          immediate generator and its decoder.
// Rev    : 1.0  initial release
// ============================================================================
package legv8_pkg;

    // Opcodes are left-aligned to a[31]; the width of each one is the width of its match field.
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4
    } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_fmt_decode.sv
`default_nettype none
// ============================================================================
// Module : imm_fmt_decode
// Brief  : Combinational classifier of instruction bits [31:21] into an
//          immediate format, first match wins.
// Rev    : 1.0  initial release
// ============================================================================
module imm_fmt_decode
    import legv8_pkg::*;
(
    input  logic [10:0] op_i,
    output imm_fmt_e    fmt_o
);

    always_comb begin
        fmt_o = FMT_NONE;
        if (op_i == OP_LDUR || op_i == OP_STUR) begin
            fmt_o = FMT_D;
        end else if (op_i[10:3] == OP_CBZ || op_i[10:3] == OP_CBNZ) begin
            fmt_o = FMT_CB;
        end else if (op_i[10:5] == OP_B) begin
            fmt_o = FMT_B;
        end else if (op_i[10:1] == OP_ADDI || op_i[10:1] == OP_SUBI) begin
            fmt_o = FMT_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sign_ext.sv
`default_nettype none
// ============================================================================
// Module : sign_ext
// Brief  : LEGv8 immediate generator; extracts and extends the immediate of
//          the current instruction, registered with one cycle of latency.
// Rev    : 1.0  initial release
// ============================================================================
module sign_ext
    import legv8_pkg::*;
#(
    parameter int DW = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] a,
    output logic [DW-1:0] y,
    output logic          y_valid
);

    imm_fmt_e      fmt;
    logic [DW-1:0] y_d;
    logic [DW-1:0] y_q;
    logic          valid_d;
    logic          valid_q;

    imm_fmt_decode u_decode (
        .op_i  (a[31:21]),
        .fmt_o (fmt)
    );

    // Branch offsets stay unscaled; the consumer applies the <<2.
    always_comb begin
        y_d     = '0;
        valid_d = 1'b1;
        case (fmt)
            FMT_D:   y_d = {{(DW-9){a[20]}},  a[20:12]};
            FMT_CB:  y_d = {{(DW-19){a[23]}}, a[23:5]};
            FMT_B:   y_d = {{(DW-26){a[25]}}, a[25:0]};
            FMT_I:   y_d = {{(DW-12){1'b0}},  a[21:10]};
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_ext.sv
`default_nettype none
// ============================================================================
// Module : tb_sign_ext
// Brief  : Scoreboard bench for sign_ext: directed vectors, a mixed random
//          stream with a mid-stream reset, checked one cycle after drive.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sign_ext;

    typedef struct {
        logic [63:0] y;
        logic        v;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [63:0] y;
    logic        y_valid;

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    sign_ext #(.DW(64), .IW(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: full-width casez on the opcode field.
    function automatic void ref_imm(input logic [31:0] ai, output logic [63:0] ey, output logic ev);
        logic [8:0]  f9;
        logic [18:0] f19;
        logic [25:0] f26;
        ev = 1'b1;
        f9  = ai[20:12];
        f19 = ai[23:5];
        f26 = ai[25:0];
        casez (ai[31:21])
            11'b11111000010, 11'b11111000000: ey = 64'($signed(f9));
            11'b1011010????:                  ey = 64'($signed(f19));
            11'b000101?????:                  ey = 64'($signed(f26));
            11'b1001000100?, 11'b1101000100?: ey = {52'd0, ai[21:10]};
            default: begin
                ey = 64'd0;
                ev = 1'b0;
            end
        endcase
    endfunction

    task automatic drive(input logic r, input logic [31:0] ai, input logic [63:0] ey,
                         input logic ev, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = r;
        a     = ai;
        e.y   = ey;
        e.v   = ev;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({got.tag, ".y"}, y, got.y);
        check({got.tag, ".v"}, {63'd0, y_valid}, {63'd0, got.v});
    endtask

    task automatic drive_model(input logic r, input logic [31:0] ai, input string tag);
        logic [63:0] ey;
        logic        ev;
        ref_imm(ai, ey, ev);
        if (r) begin
            ey = 64'd0;
            ev = 1'b0;
        end
        drive(r, ai, ey, ev, tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic        alt;
        r   = $urandom;
        alt = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0:       return {(alt ? 11'b11111000010 : 11'b11111000000), r[20:0]};
            1:       return {(alt ? 8'b10110100 : 8'b10110101), r[23:0]};
            2:       return {6'b000101, r[25:0]};
            3:       return {(alt ? 10'b1001000100 : 10'b1101000100), r[21:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        a     = 32'hF840_0000;

        drive(1'b1, 32'hF840_1000, 64'h0, 1'b0, "rst0");
        drive(1'b1, 32'hB400_0020, 64'h0, 1'b0, "rst1");

        drive(1'b0, 32'b11111000010_000000001_00_00000_00000, 64'h1,                   1'b1, "ldur_pos");
        drive(1'b0, 32'b11111000010_100000001_00_00000_00000, 64'hFFFF_FFFF_FFFF_FF01, 1'b1, "ldur_neg");
        drive(1'b0, 32'b11111000000_000001001_00_00000_00000, 64'h9,                   1'b1, "stur_pos");
        drive(1'b0, 32'b11111000000_100100001_00_00000_00000, 64'hFFFF_FFFF_FFFF_FF21, 1'b1, "stur_neg");
        drive(1'b0, 32'b11111000000_100000000_00_00000_00000, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, "d_min");
        drive(1'b0, 32'b11111000010_000000011_11_11111_11111, 64'h3,                   1'b1, "d_fields");
        drive(1'b0, 32'b10110100_000_000000001_00_00000_00000, 64'h80,                 1'b1, "cbz_pos");
        drive(1'b0, 32'b10110100_100_100000001_00_00001_00000, 64'hFFFF_FFFF_FFFC_8081, 1'b1, "cbz_neg");
        drive(1'b0, 32'b10110101_100_000000000_00_00000_11111, 64'hFFFF_FFFF_FFFC_0000, 1'b1, "cbnz_min");
        drive(1'b0, 32'b000101_10_0000_0000_0000_0000_0000_0001, 64'hFFFF_FFFF_FE00_0001, 1'b1, "b_neg");
        drive(1'b0, 32'b000101_01_1111_1111_1111_1111_1111_1111, 64'h0000_0000_01FF_FFFF, 1'b1, "b_pos");
        drive(1'b0, 32'b1001000100_111111111111_00000_00000,   64'hFFF,                1'b1, "addi_zx");
        drive(1'b0, 32'b1101000100_100000000001_11111_11111,   64'h801,                1'b1, "subi_zx");
        drive(1'b0, 32'b11111111111_000000001_00_00000_00000,  64'h0,                  1'b0, "unk0");
        drive(1'b0, 32'b11111011001_100000001_00_00000_00000,  64'h0,                  1'b0, "unk1");

        for (int i = 0; i < 40; i++) begin
            drive_model((i == 25 || i == 26), rand_instr(), $sformatf("mix%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
